// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter in front of the single-port data memory
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN (reject word-misaligned accesses with err).

module dmem_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_wren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic          cand0, cand1;
  logic          grant, grant_id;
  logic          sel_we, sel_bad;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          cmd_we, cmd_id, cmd_bad;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] rdata_q;

  // In DONE the acked port still shows its finished request, so only the other port may win.
  always_comb begin
    state_nxt = state;
    cand0     = 1'b0;
    cand1     = 1'b0;
    grant     = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        cand0 = req0;
        cand1 = req1;
      end
      BUSY: state_nxt = DONE;
      DONE: begin
        cand0     = req0 && cmd_id;
        cand1     = req1 && !cmd_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cand0 || cand1) begin
      grant     = 1'b1;
      grant_id  = (cand0 && cand1) ? ~last : cand1;
      state_nxt = BUSY;
    end
  end

  assign sel_we    = grant_id ? we1    : we0;
  assign sel_addr  = grant_id ? addr1  : addr0;
  assign sel_wdata = grant_id ? wdata1 : wdata0;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign sel_bad = (sel_addr[1:0] != 2'b00);
`else
  assign sel_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cmd_we    <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_bad   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last      <= grant_id;
        cmd_id    <= grant_id;
        cmd_we    <= sel_we;
        cmd_bad   <= sel_bad;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
      end
      if (state == BUSY && !cmd_we && !cmd_bad) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_wren  = (state == BUSY) && cmd_we && !cmd_bad;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign ack0      = (state == DONE) && !cmd_id;
  assign ack1      = (state == DONE) && cmd_id;
  assign err       = (state == DONE) && cmd_bad;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter with a transaction-timing model
// Honours DMEM_ARB_ALIGN_CHK_EN when the design is built with it.

module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, err, mem_wren;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  logic [31:0] dmem [64];

  int total = 0, passed = 0;
  int n = 0, g_edge = -100, wcnt = 0;
  bit g_id, g_we, g_ok, m_last = 1'b1;
  logic [31:0] g_addr, g_wdata, exp_rdata = '0;
  logic [31:0] ref_mem [64];
  int ack_port[$];
  int ack_cyc[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(32), .AW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en) dmem[pl_idx] <= pl_val;
    else if (mem_wren) dmem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a grant at edge g puts the access on the memory port in cycle g..g+1 and the ack
  // in cycle g+1..g+2; the next grant may come at edge g+2 (other port only) or any later edge.
  initial forever begin
    bit c0, c1, busy, done;
    int excl;
    @(negedge clk);
    if (reset_n) begin
      busy = (g_edge == n);
      done = (g_edge == n - 1);
      check("ack0", ack0, done && !g_id);
      check("ack1", ack1, done && g_id);
      check("err", err, done && !g_ok);
      check("mem_wren", mem_wren, busy && g_we && g_ok);
      check("rdata", rdata, exp_rdata);
      if (busy) begin
        check("mem_addr", mem_addr, g_addr);
        check("mem_wdata", mem_wdata, g_wdata);
      end
      if (ack0 || ack1) begin
        ack_port.push_back(ack1 ? 1 : 0);
        ack_cyc.push_back(n);
      end
      if (mem_wren) wcnt++;
    end
    n++;
    if (pl_en) ref_mem[pl_idx] = pl_val;
    if (!reset_n) begin
      g_edge = -100;
      m_last = 1'b1;
      exp_rdata = '0;
    end else begin
      if (n == g_edge + 1 && g_ok) begin
        if (g_we) ref_mem[g_addr[7:2]] = g_wdata;
        else exp_rdata = ref_mem[g_addr[7:2]];
      end
      excl = (n == g_edge + 2) ? (g_id ? 1 : 0) : -1;
      c0 = req0 && excl != 0;
      c1 = req1 && excl != 1;
      if (n >= g_edge + 2 && (c0 || c1)) begin
        g_id    = (c0 && c1) ? !m_last : c1;
        m_last  = g_id;
        g_edge  = n;
        g_we    = g_id ? we1 : we0;
        g_addr  = g_id ? addr1 : addr0;
        g_wdata = g_id ? wdata1 : wdata0;
        g_ok    = !ALIGN_CHK || (g_addr[1:0] == 2'b00);
      end
    end
  end

  task automatic drive(input int p, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    else begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // Entered and left just after a rising edge; lat counts rising edges until ack is seen.
  task automatic txn(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit e, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    drive(p, 1'b1, we, a, d);
    while (!got && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    check("ack_seen", got, 1);
    rd = rdata;
    e  = err;
    @(posedge clk);
    #1;
    drive(p, 1'b0, we, a, d);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1;
    pl_idx = 6'(idx);
    pl_val = v;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [5:0] w;
    logic [1:0] lo;
    w  = 6'($urandom_range(0, 63));
    lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return {24'h0, w, lo};
  endfunction

  initial begin
    logic [31:0] rd;
    bit e;
    int lat, w0, s;
    int c_lat0[3], c_lat1[3];
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) preload(i, $urandom);

    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    preload(3, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h0C, 32'h0, rd, e, lat);
    check("rd0_lat", lat, 2);
    check("rd0_data", rd, 32'hDEADBEEF);

    w0 = wcnt;
    txn(1, 1'b1, 32'h20, 32'h12345678, rd, e, lat);
    txn(1, 1'b0, 32'h20, 32'h0, rd, e, lat);
    check("wr1_wren_cycles", wcnt - w0, 1);
    check("wr1_readback", rd, 32'h12345678);

    preload(1, 32'h11111111);
    w0 = wcnt;
    txn(0, 1'b1, 32'h05, 32'hFFFFFFFF, rd, e, lat);
    check("misal_err", e, ALIGN_CHK ? 1 : 0);
    check("misal_wren_cycles", wcnt - w0, ALIGN_CHK ? 0 : 1);
    check("misal_word1", dmem[1], ALIGN_CHK ? 32'h11111111 : 32'hFFFFFFFF);

    preload(16, 32'h0BADF00D);
    drive(0, 1'b1, 1'b1, 32'h40, 32'hAAAA5555);
    @(posedge clk);
    #2;
    check("rstbusy_wren_before", mem_wren, 1);
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h40, 32'hAAAA5555);
    #1;
    check("rstbusy_wren", mem_wren, 0);
    check("rstbusy_ack0", ack0, 0);
    check("rstbusy_ack1", ack1, 0);
    check("rstbusy_err", err, 0);
    check("rstbusy_rdata", rdata, 0);
    check("rstbusy_addr", mem_addr, 0);
    check("rstbusy_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rstbusy_word16", dmem[16], 32'h0BADF00D);
    txn(0, 1'b0, 32'h40, 32'h0, rd, e, lat);
    check("rstbusy_fresh_lat", lat, 2);
    check("rstbusy_fresh_data", rd, 32'h0BADF00D);

    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s = ack_port.size();
    fork
      begin
        logic [31:0] rd0; bit e0;
        for (int k = 0; k < 3; k++) txn(0, 1'b0, rand_addr(), 32'h0, rd0, e0, c_lat0[k]);
      end
      begin
        logic [31:0] rd1; bit e1;
        for (int k = 0; k < 3; k++) txn(1, 1'b0, rand_addr(), 32'h0, rd1, e1, c_lat1[k]);
      end
    join
    check("cont_lat0", c_lat0[0], 2);
    check("cont_lat1", c_lat1[0], 4);
    check("cont_acks", ack_port.size() - s, 6);
    for (int i = 0; i < 6 && s + i < ack_port.size(); i++) begin
      check("cont_order", ack_port[s+i], i % 2);
      if (i > 0) check("cont_spacing", ack_cyc[s+i] - ack_cyc[s+i-1], 2);
    end

    fork
      begin
        logic [31:0] rd0; bit e0; int l0;
        for (int k = 0; k < 4; k++) txn(0, 1'b1, rand_addr(), $urandom, rd0, e0, l0);
      end
      begin
        logic [31:0] rd1; bit e1; int l1;
        repeat (4) @(posedge clk);
        #1;
        txn(1, 1'b0, rand_addr(), 32'h0, rd1, e1, l1);
        check("starve_lat_le4", l1 <= 4, 1);
      end
    join

    fork
      begin
        logic [31:0] rd0; bit e0; int l0, g;
        for (int k = 0; k < 40; k++) begin
          g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          txn(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, rd0, e0, l0);
          check("rand_lat0_le4", l0 <= 4, 1);
        end
      end
      begin
        logic [31:0] rd1; bit e1; int l1, g;
        for (int k = 0; k < 40; k++) begin
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          txn(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, rd1, e1, l1);
          check("rand_lat1_le4", l1 <= 4, 1);
        end
      end
    join

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (`dmem`: 64 × 32-bit words, word-indexed by `addr[31:2]`, combinational read, write on rising `clk`) between the CPU load/store unit (port 0) and a secondary master such as a debug/DMA engine (port 1). It accepts one request at a time with round-robin priority and drives the memory port from registered command state. It returns registered read data and a one-cycle acknowledge to the winning requester. The block sits between the requesters and `dmem`, and is the only driver of the `dmem` port.

## Interface
- `DW`, 32, data width (must match `dmem`)
- `AW`, 32, address width (byte address)

- `clk` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `req0` / `req1` in 1: request from port 0 / port 1; held high until that port's `ack`
- `we0` / `we1` in 1: 1 = write, 0 = read; stable while `req` is high
- `addr0` / `addr1` in AW: byte address; stable while `req` is high
- `wdata0` / `wdata1` in DW: write data; stable while `req` is high
- `ack0` / `ack1` out 1: one-cycle completion pulse
- `rdata` out DW: read data, valid in the `ack` cycle, shared by both ports
- `err` out 1: access rejected, valid in the `ack` cycle (see Configuration)
- `mem_wren` out 1: to `dmem` `wren`
- `mem_addr` out AW: to `dmem` `addr`
- `mem_wdata` out DW: to `dmem` `wdata`
- `mem_rdata` in DW: from `dmem` `rdata`

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE:** at each rising edge with any `req` high, pick a winner, latch its `we`/`addr`/`wdata` and id into command registers, and go to BUSY.
- **Arbitration:** round-robin via `last`, which holds the id of the last granted port.
  - If both ports request, the port ≠ `last` wins.
  - If one port requests, it wins.
  - `last` resets to 1, so port 0 wins the first contention.
  - `last` updates on every grant.
- **BUSY:** drive `mem_addr`/`mem_wdata` from the command registers, and `mem_wren` = latched `we` (and not rejected).
  - At the closing edge: the write commits in `dmem`, `mem_rdata` is captured into `rdata` (for reads), and the state goes to DONE.
- **DONE:** pulse `ack` for the granted port. `rdata` and `err` are valid this cycle.
  - At the closing edge, arbitrate again, but exclude the port being acked: its inputs still show the completed transaction.
  - If the other port requests, grant it and go to BUSY; otherwise go to IDLE.
- **Writes:** `rdata` is left unchanged, which matches the reset value 0 until the first read.
- **Sole requester:** a port that is alone sustains one access per 3 cycles. Two ports alternate at one access per 2 cycles.
- Requests are never dropped or reordered. A `req` deasserted before its `ack` is a protocol violation, and the behaviour is undefined.

## Timing
- Request seen at edge E0 (in IDLE) → `mem_*` valid in cycle E0–E1 → `ack` high in cycle E1–E2. Req-to-ack latency is 2 cycles.
- `mem_wren` is high only in BUSY, for exactly one cycle per write. It is 0 in IDLE and DONE.
- `ack0` and `ack1` are never high together. Each is high for exactly one cycle.
- Reset values: `ack0`=`ack1`=0, `err`=0, `rdata`=0, `mem_wren`=0, `mem_addr`=0, `mem_wdata`=0, `last`=1, state IDLE.
- **Reset mid-operation:** `reset_n` low clears everything asynchronously.
  - `mem_wren` falls immediately, so a BUSY write may not commit.
  - No `ack` is issued for the aborted request. The requester must reissue it after reset.
- All outputs are registered or decoded from state/registers only. There is no combinational path from `req*` to any output.

## Configuration
- `DMEM_ARB_ALIGN_CHK_EN` defined: a latched address with `addr[1:0]` ≠ 0 is rejected.
  - In BUSY, `mem_wren` is forced to 0 and `rdata` is not updated.
  - In DONE, `err`=1 alongside `ack`.
  - Latency and arbitration are unchanged.
- Not defined: `err` is tied to 0, and `addr[1:0]` is ignored (the word index is `addr[31:2]`, matching `dmem`).

## Test plan
- **Single read, port 0:** preload word 3 = 0xDEADBEEF; `req0`, `we0`=0, `addr0`=0x0C → `ack0` exactly 2 cycles later, `rdata`=0xDEADBEEF, `ack1`=0.
- **Write then read, port 1:** write 0x12345678 to 0x20, wait for `ack1`, then read 0x20 → `mem_wren` high for exactly one cycle, second `ack1` returns `rdata`=0x12345678.
- **Contention:** `req0` and `req1` rise on the same edge after reset → port 0 served first (`ack0`), then `ack1` 2 cycles later. With both held continuously, acks alternate 0,1,0,1, one per 2 cycles.
- **Starvation check:** port 0 issues back-to-back requests while port 1 requests once → port 1 is acked within 4 cycles of its `req1`.
- **Reset mid-BUSY:** assert `reset_n`=0 during a BUSY write of 0xAAAA5555 → `mem_wren` drops the same cycle, no `ack`, all outputs return to reset values, and a fresh request after release completes normally.
- **Alignment** (with `DMEM_ARB_ALIGN_CHK_EN`): write 0xFFFFFFFF to 0x05 → `ack0` with `err`=1, `mem_wren` never high, word 1 unchanged. Without the macro, word 1 = 0xFFFFFFFF and `err`=0.
